rxecrc: RTL and testbench

- Receive-side counterpart of the Ethernet TX CRC inserter.
- Accepts a nibble stream from the RX PHY path (preamble already removed), low nibble of each byte first.
- Computes the reflected CRC-32 over the whole frame and strips the trailing 8 FCS nibbles from the output stream.
- Flags a CRC mismatch with a one-cycle error strobe at end of frame.
- Sits between the RX nibble deframer and the RX byte packer/buffer.

---
 rtl/rxecrc_pkg.sv | 39 +++
 rtl/rxecrc_if.sv | 31 +++
 rtl/rxecrc_nibble_delay8.sv | 58 +++++
 rtl/rxecrc.sv | 109 ++++++++++
 tb/tb_rxecrc.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/rxecrc_pkg.sv
// ----------------------------------------------------------------------------
// rxecrc_pkg
//   Shared Ethernet CRC definitions used by both the TX CRC inserter and the
//   RX CRC checker. Both sides use the same update function, so their tables
//   cannot drift apart.
//   Contents:
//     NIB_W, DLY_DEPTH         - nibble width and FCS length in nibbles
//     CRC32_POLY/INIT/RESIDUE  - reflected CRC-32 constants
//     crc32_nibble()           - one-nibble reflected CRC-32 update
// ----------------------------------------------------------------------------
package rxecrc_pkg;

    localparam int          NIB_W         = 4;
    localparam int          DLY_DEPTH     = 8;

    localparam logic [31:0] CRC32_POLY    = 32'hedb88320;
    localparam logic [31:0] CRC32_INIT    = 32'hffffffff;
    localparam logic [31:0] CRC32_RESIDUE = 32'hdebb20e3;

    // The low five bits of POLY are zero. Because of that, the four
    // single-bit steps fold into four independent shifted copies of POLY,
    // with no cross terms between them.
    function automatic logic [31:0] crc32_nibble(input logic [31:0]      crc,
                                                 input logic [NIB_W-1:0] d,
                                                 input logic [31:0]      poly);
        logic [3:0]  low;
        logic [31:0] nxt;
        // NOTE: blocking '=' is right in combinational code; each line uses
        // the value just computed. Registers take '<=' in always_ff only.
        low = crc[3:0] ^ d;
        nxt = crc >> 4;
        if (low[0]) nxt = nxt ^ (poly >> 3);
        if (low[1]) nxt = nxt ^ (poly >> 2);
        if (low[2]) nxt = nxt ^ (poly >> 1);
        if (low[3]) nxt = nxt ^ poly;
        return nxt;
    endfunction

endpackage

// File: rtl/rxecrc_if.sv
// ----------------------------------------------------------------------------
// rxecrc_if
//   Nibble-stream bundle between the RX deframer side and the CRC checker.
//   i_ce, i_en, i_cancel, i_v, i_d : toward the checker
//   o_v, o_d, o_done, o_err        : from the checker
//   master = stimulus / upstream side, slave = rxecrc
// ----------------------------------------------------------------------------
interface rxecrc_if;
    import rxecrc_pkg::*;

    logic             i_ce;
    logic             i_en;
    logic             i_cancel;
    logic             i_v;
    logic [NIB_W-1:0] i_d;
    logic             o_v;
    logic [NIB_W-1:0] o_d;
    logic             o_done;
    logic             o_err;

    modport master (
        output i_ce, i_en, i_cancel, i_v, i_d,
        input  o_v, o_d, o_done, o_err
    );

    modport slave (
        input  i_ce, i_en, i_cancel, i_v, i_d,
        output o_v, o_d, o_done, o_err
    );

endinterface

// File: rtl/rxecrc_nibble_delay8.sv
// ----------------------------------------------------------------------------
// rxecrc_nibble_delay8
//   8-deep nibble shift register with a saturating fill counter (0..8).
//   It holds back the trailing FCS nibbles until the frame is known to
//   continue.
//   i_clk, i_reset_n : clock, async active-low reset
//   i_ce             : clock enable
//   i_clear          : drop contents (fill -> 0); has priority over i_push
//   i_push, i_d      : shift a nibble in
//   o_oldest         : nibble pushed 8 pushes ago (valid when o_full)
//   o_full           : fill == 8
// ----------------------------------------------------------------------------
module rxecrc_nibble_delay8
    import rxecrc_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_ce,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [NIB_W-1:0] i_d,
    output logic [NIB_W-1:0] o_oldest,
    output logic             o_full
);

    localparam logic [3:0] FILL_MAX = 4'(DLY_DEPTH);

    logic [NIB_W-1:0] sr_q [DLY_DEPTH];
    logic [3:0]       fill_q, fill_d;

    always_comb begin
        fill_d = fill_q;
        if (i_clear)
            fill_d = '0;
        else if (i_push && fill_q != FILL_MAX)
            fill_d = fill_q + 4'd1;
    end

    // NOTE: the shift register is small and its contents are defined to be
    // cleared by reset, so it is reset here. Large RAM-style memories would
    // normally be left unreset and qualified by the fill count instead.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < DLY_DEPTH; i++) sr_q[i] <= '0;
            fill_q <= '0;
        end else if (i_ce) begin
            fill_q <= fill_d;
            if (i_push && !i_clear) begin
                sr_q[0] <= i_d;
                for (int i = 1; i < DLY_DEPTH; i++) sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign o_oldest = sr_q[DLY_DEPTH-1];
    assign o_full   = (fill_q == FILL_MAX);

endmodule

// File: rtl/rxecrc.sv
// ----------------------------------------------------------------------------
// rxecrc
//   RX CRC-32 checker and FCS stripper for a low-nibble-first nibble stream.
//   With i_en=1 it delays payload by 8 nibbles, so the FCS never reaches the
//   output. At frame end it strobes o_done, and o_err on a bad CRC or a runt
//   frame. With i_en=0 it passes nibbles through with 1-cycle latency.
//   i_clk, i_reset_n : clock, async active-low reset
//   bus (slave)      : i_ce/i_en/i_cancel/i_v/i_d in, o_v/o_d/o_done/o_err out
// ----------------------------------------------------------------------------
module rxecrc
    import rxecrc_pkg::*;
#(
    parameter logic [31:0] INIT    = CRC32_INIT,
    parameter logic [31:0] RESIDUE = CRC32_RESIDUE,
    parameter logic [31:0] POLY    = CRC32_POLY
) (
    input  logic  i_clk,
    input  logic  i_reset_n,
    rxecrc_if.slave bus
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [31:0]      crc_q,   crc_d;
    logic             ov_q,    ov_d;
    logic [NIB_W-1:0] od_q,    od_d;
    logic             done_q,  done_d;
    logic             err_q,   err_d;

    logic             dly_push, dly_clear, dly_full;
    logic [NIB_W-1:0] dly_oldest;

    rxecrc_nibble_delay8 u_dly (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_ce      (bus.i_ce),
        .i_clear   (dly_clear),
        .i_push    (dly_push),
        .i_d       (bus.i_d),
        .o_oldest  (dly_oldest),
        .o_full    (dly_full)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d   = state_q;
        crc_d     = crc_q;
        ov_d      = 1'b0;
        od_d      = od_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        dly_push  = 1'b0;
        dly_clear = 1'b0;

        if (bus.i_cancel) begin
            // Abort: silent return to IDLE, no end-of-frame strobes.
            crc_d     = INIT;
            dly_clear = 1'b1;
            state_d   = ST_IDLE;
        end else if (bus.i_v) begin
            dly_push = 1'b1;
            crc_d    = crc32_nibble((state_q == ST_IDLE) ? INIT : crc_q,
                                    bus.i_d, POLY);
            state_d  = ST_BUSY;
            if (!bus.i_en) begin
                ov_d = 1'b1;
                od_d = bus.i_d;
            end else if (dly_full) begin
                // Any nibble with 8 more behind it cannot be FCS.
                ov_d = 1'b1;
                od_d = dly_oldest;
            end
        end else if (state_q == ST_BUSY) begin
            // End of frame: the 8 buffered nibbles are the FCS and are dropped.
            done_d    = 1'b1;
            err_d     = bus.i_en && (!dly_full || crc_q != RESIDUE);
            crc_d     = INIT;
            dly_clear = 1'b1;
            state_d   = ST_IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            crc_q   <= INIT;
            ov_q    <= 1'b0;
            od_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (bus.i_ce) begin
            state_q <= state_d;
            crc_q   <= crc_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.o_v    = ov_q;
    assign bus.o_d    = od_q;
    assign bus.o_done = done_q;
    assign bus.o_err  = err_q;

endmodule

// File: tb/tb_rxecrc.sv
// ----------------------------------------------------------------------------
// tb_rxecrc
//   Directed bench for rxecrc: good, corrupt, runt, cancel, passthrough,
//   clock-enable gaps and a mid-frame reset, using the "123456789" frame.
// ----------------------------------------------------------------------------
module tb_rxecrc;

    logic i_clk     = 1'b0;
    logic i_reset_n = 1'b0;

    rxecrc_if bus ();

    rxecrc dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .bus       (bus)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // "123456789" low nibble first, then FCS 0xCBF43926 sent as 26 39 F4 CB.
    localparam logic [3:0] GOOD [26] = '{
        4'h1, 4'h3, 4'h2, 4'h3, 4'h3, 4'h3, 4'h4, 4'h3, 4'h5, 4'h3,
        4'h6, 4'h3, 4'h7, 4'h3, 4'h8, 4'h3, 4'h9, 4'h3,
        4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC
    };

    logic [3:0] frm [26];
    logic [3:0] got_q [$];
    int         first_idx, done_cnt, err_cnt, misplaced, hold_bad;

    task automatic drive_idle();
        bus.i_ce     = 1'b1;
        bus.i_cancel = 1'b0;
        bus.i_v      = 1'b0;
        bus.i_d      = 4'h0;
    endtask

    // Send frm[0..n-1], then one i_v=0 cycle. Outputs are sampled 1 ns after
    // each enabled edge. A non-negative cancel_idx raises i_cancel on that
    // nibble and abandons the frame.
    task automatic run_frame(input int n, input logic en, input int cancel_idx,
                             input bit ce_toggle);
        logic       ov_s;
        logic [3:0] od_s;
        got_q.delete();
        first_idx = -1; done_cnt = 0; err_cnt = 0; misplaced = 0; hold_bad = 0;
        bus.i_en = en;
        for (int i = 0; i <= n; i++) begin
            bus.i_ce     = 1'b1;
            bus.i_v      = (i < n);
            bus.i_d      = (i < n) ? frm[i] : 4'h0;
            bus.i_cancel = (i == cancel_idx);
            @(posedge i_clk); #1;
            if (bus.o_v) begin
                if (first_idx < 0) first_idx = i;
                got_q.push_back(bus.o_d);
            end
            if (bus.o_done) done_cnt++;
            if (bus.o_err)  err_cnt++;
            if ((bus.o_done || bus.o_err) && i != n) misplaced++;
            if (i == cancel_idx) begin
                check("cancel_ov", 32'(bus.o_v), 32'd0);
                break;
            end
            if (ce_toggle && i < n) begin
                ov_s     = bus.o_v;
                od_s     = bus.o_d;
                bus.i_ce = 1'b0;
                repeat (2) begin
                    @(posedge i_clk); #1;
                    if (bus.o_v !== ov_s || bus.o_d !== od_s || bus.o_done || bus.o_err)
                        hold_bad++;
                end
            end
        end
        drive_idle();
        @(posedge i_clk); #1;
        if (bus.o_done || bus.o_err) misplaced++;
    endtask

    task automatic expect_frame(input string tag, input int n_out, input int first_exp,
                                input int done_exp, input int err_exp);
        check({tag, "_count"}, 32'(got_q.size()), 32'(n_out));
        for (int k = 0; k < n_out && k < got_q.size(); k++)
            check($sformatf("%s_nib%0d", tag, k), 32'(got_q[k]), 32'(frm[k]));
        check({tag, "_first"},     32'(first_idx), 32'(first_exp));
        check({tag, "_done"},      32'(done_cnt),  32'(done_exp));
        check({tag, "_err"},       32'(err_cnt),   32'(err_exp));
        check({tag, "_misplaced"}, 32'(misplaced), 32'd0);
        check({tag, "_hold"},      32'(hold_bad),  32'd0);
    endtask

    initial begin
        drive_idle();
        bus.i_en = 1'b1;
        #1;
        check("rst_ov",   32'(bus.o_v),    32'd0);
        check("rst_od",   32'(bus.o_d),    32'd0);
        check("rst_done", 32'(bus.o_done), 32'd0);
        check("rst_err",  32'(bus.o_err),  32'd0);
        repeat (2) @(posedge i_clk);
        #3 i_reset_n = 1'b1;

        // Good frame: 18 payload nibbles, first seen after nibble 8.
        frm = GOOD;
        run_frame(26, 1'b1, -1, 1'b0);
        expect_frame("good", 18, 8, 1, 0);

        // Corrupt payload nibble 5.
        frm[5] = 4'h2;
        run_frame(26, 1'b1, -1, 1'b0);
        expect_frame("corrupt", 18, 8, 1, 1);
        frm = GOOD;

        // Runt frame: too short to hold an FCS.
        run_frame(5, 1'b1, -1, 1'b0);
        expect_frame("runt", 0, -1, 1, 1);

        // Cancel on the 12th nibble: nibbles 0..2 were already out.
        run_frame(26, 1'b1, 11, 1'b0);
        expect_frame("cancel", 3, 8, 0, 0);
        run_frame(26, 1'b1, -1, 1'b0);
        expect_frame("after_cancel", 18, 8, 1, 0);

        // Passthrough: all 26 nibbles with 1-cycle latency, no check.
        run_frame(26, 1'b0, -1, 1'b0);
        expect_frame("pass", 26, 0, 1, 0);

        // Clock-enable gaps 1,0,0,1,...
        run_frame(26, 1'b1, -1, 1'b1);
        expect_frame("ce_gap", 18, 8, 1, 0);

        // Mid-frame reset once output is flowing.
        bus.i_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.i_v = 1'b1;
            bus.i_d = frm[i];
            @(posedge i_clk); #1;
        end
        check("pre_rst_ov", 32'(bus.o_v), 32'd1);
        #3 i_reset_n = 1'b0;
        #1;
        check("mid_rst_ov",   32'(bus.o_v),    32'd0);
        check("mid_rst_od",   32'(bus.o_d),    32'd0);
        check("mid_rst_done", 32'(bus.o_done), 32'd0);
        check("mid_rst_err",  32'(bus.o_err),  32'd0);
        drive_idle();
        @(posedge i_clk);
        #3 i_reset_n = 1'b1;
        run_frame(26, 1'b1, -1, 1'b0);
        expect_frame("after_rst", 18, 8, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
